rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that shares one downstream resource (a single-port RAM or ALU port) among eight requesters. It reuses the existing Or8Way gate as its "any request pending" detector, issues a registered one-hot grant, holds that grant while the owner keeps requesting, and can pre-empt a long holder. The block sits between the requester bank and the shared datapath's select/mux logic.

---
 rtl/rr_arbiter8_pkg.sv | 12 +
 rtl/Or8Way.sv | 7 +
 rtl/rr_pick8.sv | 19 +
 rtl/rr_arbiter8.sv | 76 +++++++
 tb/tb_rr_arbiter8.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared state encodings, index widths and one-hot helper for the 8-way arbiter
package rr_arbiter8_pkg;
    localparam int N = 8;
    localparam int IDX_W = 3;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_t;
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/Or8Way.sv
// Or8Way: eight-input OR gate, used as the any-request detector
module Or8Way (
    input  logic [7:0] in,
    output logic       out
);
    assign out = |in;
endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: first unmasked request found scanning circularly upward from ptr
module rr_pick8 import rr_arbiter8_pkg::*; (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [N-1:0] cand;
    assign cand  = req & ~mask;
    assign found = |cand;
    // scan from the far end back toward ptr so the nearest candidate is assigned last
    always_comb begin
        idx = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[ptr + IDX_W'(k)]) idx = ptr + IDX_W'(k);
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot grant and hold-time pre-emption
module rr_arbiter8 import rr_arbiter8_pkg::*; #(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy
);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    arb_state_t       state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx, owner, owner_nx, pick_ptr, idx;
    logic [HW-1:0]    hold, hold_nx;
    logic [N-1:0]     pick_mask;
    logic             any, found, preempt;

    Or8Way u_any (.in(req), .out(any));

    // while granted, the search restarts just past the owner and never picks the owner itself
    assign pick_ptr  = (state == ARB_GRANT) ? owner + 3'd1 : ptr;
    assign pick_mask = (state == ARB_GRANT) ? onehot(owner) : '0;

    rr_pick8 u_pick (.req(req), .ptr(pick_ptr), .mask(pick_mask), .found(found), .idx(idx));

    assign preempt  = (MAX_HOLD != 0) && (hold == HOLD_LAST) && found;
    assign grant_id = owner;

    // next-state: release wins over pre-emption; hold counter saturates at HOLD_LAST
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        hold_nx  = hold;
        if (state == ARB_IDLE) begin
            if (any) begin
                state_nx = ARB_GRANT;
                owner_nx = idx;
                hold_nx  = '0;
            end
        end else if (!req[owner]) begin
            ptr_nx   = owner + 3'd1;
            hold_nx  = '0;
            state_nx = found ? ARB_GRANT : ARB_IDLE;
            owner_nx = found ? idx : owner;
        end else if (preempt) begin
            ptr_nx   = owner + 3'd1;
            owner_nx = idx;
            hold_nx  = '0;
        end else if (hold != HOLD_LAST) begin
            hold_nx = hold + 1'b1;
        end
    end

    // state and output registers; grant and busy are precomputed so outputs come straight from flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            owner <= '0;
            hold  <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            owner <= owner_nx;
            hold  <= hold_nx;
            grant <= (state_nx == ARB_GRANT) ? onehot(owner_nx) : '0;
            busy  <= (state_nx == ARB_GRANT);
        end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench driving MAX_HOLD=4 and MAX_HOLD=0 arbiters from one request stream
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] g4, g0;
    logic [2:0] id4, id0;
    logic       b4, b0;
    int         n_tests = 0;
    int         n_fail = 0;

    typedef struct packed {
        logic [7:0] g4, g0;
        logic [2:0] id4, id0;
        logic       b4, b0;
    } exp_t;
    exp_t sb[$];

    int m_busy[2], m_owner[2], m_ptr[2], m_hold[2];
    int mh[2] = '{4, 0};

    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (.clk(clk), .reset(reset), .req(req), .grant(g4), .grant_id(id4), .busy(b4));
    rr_arbiter8 #(.MAX_HOLD(0)) dut0 (.clk(clk), .reset(reset), .req(req), .grant(g0), .grant_id(id0), .busy(b0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int mpick(input logic [7:0] r, input int start, input int excl);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start + k) % 8;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 0; m_owner[u] = 0; m_ptr[u] = 0; m_hold[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [7:0] r);
        int o;
        o = m_owner[u];
        if (m_busy[u] == 0) begin
            if (r != 0) begin
                m_busy[u] = 1; m_owner[u] = mpick(r, m_ptr[u], -1); m_hold[u] = 0;
            end
        end else if (!r[o]) begin
            m_ptr[u] = (o + 1) % 8;
            m_hold[u] = 0;
            if (r != 0) m_owner[u] = mpick(r, m_ptr[u], -1);
            else m_busy[u] = 0;
        end else if (mh[u] != 0 && m_hold[u] == mh[u] - 1 && mpick(r, 0, o) >= 0) begin
            m_ptr[u] = (o + 1) % 8;
            m_owner[u] = mpick(r, m_ptr[u], o);
            m_hold[u] = 0;
        end else if (mh[u] != 0 && m_hold[u] < mh[u] - 1) begin
            m_hold[u]++;
        end
    endtask

    function automatic logic [7:0] mgrant(input int u);
        return m_busy[u] != 0 ? (8'h01 << m_owner[u]) : 8'h00;
    endfunction

    task automatic step(input logic [7:0] r);
        exp_t e;
        @(negedge clk);
        req = r;
        model_step(0, r);
        model_step(1, r);
        e.g4 = mgrant(0); e.g0 = mgrant(1);
        e.id4 = 3'(m_owner[0]); e.id0 = 3'(m_owner[1]);
        e.b4 = m_busy[0] != 0; e.b0 = m_busy[1] != 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("grant4", g4, e.g4);
        chk("grant0", g0, e.g0);
        chk("busy4", b4, e.b4);
        chk("busy0", b0, e.b0);
        if (e.b4) chk("id4", id4, e.id4);
        if (e.b0) chk("id0", id0, e.id0);
        chk("onehot4", $countones(g4) <= 1, 1);
        chk("onehot0", $countones(g0) <= 1, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_g4", g4, 8'h00);
        chk("rst_g0", g0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        req = 8'h00;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre_tbl [13];
        logic [7:0] cur;
        pre_tbl = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h08, 8'h08, 8'h08, 8'h08,
                    8'h10, 8'h10, 8'h10, 8'h10, 8'h01};
        model_reset();
        #12;
        chk("rst_grant4", g4, 8'h00);
        chk("rst_grant0", g0, 8'h00);
        chk("rst_busy4", b4, 1'b0);
        chk("rst_id4", id4, 3'd0);
        chk("rst_id0", id0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            step(8'h00);
            chk("idle_id4", id4, 3'd0);
        end
        step(8'h01);
        chk("single_g", g4, 8'h01);
        chk("single_id", id4, 3'd0);
        step(8'h00);
        chk("single_drop", g4, 8'h00);
        step(8'h03);
        chk("ptr_after_drop", g4, 8'h02);
        step(8'h00);

        do_reset();
        step(8'hFF);
        chk("rr_first", g4, 8'h01);
        cur = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            step(~cur);
            cur = 8'h01 << (i % 8);
            chk("rr_seq4", g4, cur);
            chk("rr_seq0", g0, cur);
        end

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(8'h19);
            chk("preempt4", g4, pre_tbl[i]);
            chk("nopreempt0", g0, 8'h01);
        end

        do_reset();
        repeat (22) begin
            step(8'h20);
            chk("lone4", g4, 8'h20);
        end

        do_reset();
        repeat (4) step(8'h03);
        step(8'h06);
        chk("rel_timeout", g4, 8'h02);
        step(8'h05);
        chk("rel_timeout_next", g4, 8'h04);

        step(8'h80);
        step(8'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("async_g4", g4, 8'h00);
        chk("async_g0", g0, 8'h00);
        chk("async_busy", b4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        repeat (60) step(8'($urandom));
        repeat (3) step(8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
